// File: rtl/dual_port_onchip_memory.sv
// True-dual-port on-chip RAM with two Avalon-MM slave ports, byte enables,
// pipelined reads (latency 1 or 2) and a saturating write/write collision counter.
module dual_port_onchip_memory #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 15,
    parameter int NUM_WORDS    = 32768,
    parameter int READ_LATENCY = 1,
    // Image name handed to the vendor memory-initialisation flow; "" leaves contents undefined.
    parameter     INIT_FILE    = ""
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [DATA_WIDTH/8-1:0] a_byteenable,
    input  logic                    a_chipselect,
    input  logic                    a_read,
    input  logic                    a_write,
    input  logic [DATA_WIDTH-1:0]   a_writedata,
    input  logic                    a_clken,
    output logic                    a_waitrequest,
    output logic [DATA_WIDTH-1:0]   a_readdata,
    output logic                    a_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]   b_address,
    input  logic [DATA_WIDTH/8-1:0] b_byteenable,
    input  logic                    b_chipselect,
    input  logic                    b_read,
    input  logic                    b_write,
    input  logic [DATA_WIDTH-1:0]   b_writedata,
    input  logic                    b_clken,
    output logic                    b_waitrequest,
    output logic [DATA_WIDTH-1:0]   b_readdata,
    output logic                    b_readdatavalid,

    output logic [15:0]             collision_count
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(NUM_WORDS);

    // Index 0 is port A, index 1 is port B.
    logic [1:0][ADDR_WIDTH-1:0] address;
    logic [1:0][NB-1:0]         byteenable;
    logic [1:0][DATA_WIDTH-1:0] writedata;
    logic [1:0][DATA_WIDTH-1:0] ram_q;
    logic [1:0][DATA_WIDTH-1:0] readdata;
    logic [1:0]                 chipselect;
    logic [1:0]                 rd_req;
    logic [1:0]                 wr_req;
    logic [1:0]                 clken;
    logic [1:0]                 readdatavalid;
    logic [1:0]                 in_range;
    logic [1:0]                 wr_en;
    logic [1:0]                 rd_acc;
    logic [1:0][IW-1:0]         idx;
    logic [1:0][NB-1:0]         lane_wr;

    logic                       collide;
    logic [15:0]                count_reg;

    assign address    = {b_address,    a_address};
    assign byteenable = {b_byteenable, a_byteenable};
    assign writedata  = {b_writedata,  a_writedata};
    assign chipselect = {b_chipselect, a_chipselect};
    assign rd_req     = {b_read,       a_read};
    assign wr_req     = {b_write,      a_write};
    assign clken      = {b_clken,      a_clken};

    assign a_waitrequest   = ~a_clken;
    assign b_waitrequest   = ~b_clken;
    assign a_readdata      = readdata[0];
    assign b_readdata      = readdata[1];
    assign a_readdatavalid = readdatavalid[0];
    assign b_readdatavalid = readdatavalid[1];
    assign collision_count = count_reg;

    genvar gi;

    for (gi = 0; gi < 2; gi++) begin : g_port
        logic                  req;
        logic                  v1_reg;
        logic                  ok1_reg;
        logic [DATA_WIDTH-1:0] data1;
        logic                  out_valid;
        logic [DATA_WIDTH-1:0] out_data;

        assign in_range[gi] = {1'b0, address[gi]} < DEPTH;
        // Out-of-range accesses are steered to word 0; writes are masked and reads zeroed.
        assign idx[gi]      = in_range[gi] ? address[gi][IW-1:0] : '0;
        assign req          = chipselect[gi] & clken[gi] & ~reset;
        assign wr_en[gi]    = req & wr_req[gi] & in_range[gi];
        assign rd_acc[gi]   = req & rd_req[gi] & ~wr_req[gi];
        assign lane_wr[gi]  = wr_en[gi] ? byteenable[gi] : '0;

        always_ff @(posedge clk) begin
            if (reset) begin
                v1_reg  <= 1'b0;
                ok1_reg <= 1'b0;
            end else if (clken[gi]) begin
                v1_reg <= rd_acc[gi];
                if (rd_acc[gi]) begin
                    ok1_reg <= in_range[gi];
                end
            end
        end

        // ok1_reg also forces readdata to zero after reset without touching the RAM register.
        assign data1 = ok1_reg ? ram_q[gi] : '0;

        if (READ_LATENCY >= 2) begin : g_lat2
            logic                  v2_reg;
            logic [DATA_WIDTH-1:0] d2_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    v2_reg <= 1'b0;
                    d2_reg <= '0;
                end else if (clken[gi]) begin
                    v2_reg <= v1_reg;
                    if (v1_reg) begin
                        d2_reg <= data1;
                    end
                end
            end

            assign out_valid = v2_reg;
            assign out_data  = d2_reg;
        end else begin : g_lat1
            assign out_valid = v1_reg;
            assign out_data  = data1;
        end

        // A stalled port keeps its pending result until clken returns, then pulses once.
        assign readdatavalid[gi] = out_valid & clken[gi] & ~reset;
        assign readdata[gi]      = out_data;
    end

    for (gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] mem [NUM_WORDS];
        logic [7:0] q_a_reg;
        logic [7:0] q_b_reg;
        logic       b_blocked;

        // Port A owns any lane both ports write to the same word in the same cycle.
        assign b_blocked = lane_wr[0][gi] && (idx[0] == idx[1]);

        always_ff @(posedge clk) begin
            if (lane_wr[0][gi]) begin
                mem[idx[0]] <= writedata[0][8*gi +: 8];
            end
            if (lane_wr[1][gi] && !b_blocked) begin
                mem[idx[1]] <= writedata[1][8*gi +: 8];
            end
            if (rd_acc[0]) begin
                q_a_reg <= mem[idx[0]];
            end
            if (rd_acc[1]) begin
                q_b_reg <= mem[idx[1]];
            end
        end

        assign ram_q[0][8*gi +: 8] = q_a_reg;
        assign ram_q[1][8*gi +: 8] = q_b_reg;
    end

    assign collide = wr_en[0] & wr_en[1] & (idx[0] == idx[1]) & (|(lane_wr[0] & lane_wr[1]));

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (collide && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_dual_port_onchip_memory.sv
// Directed bench driving a latency-1 and a latency-2 instance with identical stimulus;
// a negedge monitor logs every readdatavalid pulse with its cycle number.
module tb_dual_port_onchip_memory;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NW = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] a_address, b_address;
    logic [3:0]    a_byteenable, b_byteenable;
    logic          a_chipselect, b_chipselect;
    logic          a_read, b_read, a_write, b_write;
    logic [DW-1:0] a_writedata, b_writedata;
    logic          a_clken, b_clken;

    logic [1:0]          a_waitrequest, b_waitrequest;
    logic [1:0]          a_rvalid, b_rvalid;
    logic [1:0][DW-1:0]  a_rdata, b_rdata;
    logic [1:0][15:0]    coll;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic        port;
        logic        inst;
        logic [31:0] data;
    } ev_t;

    ev_t ev_q[$];

    always #5 clk = ~clk;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_dut
        dual_port_onchip_memory #(
            .DATA_WIDTH  (DW),
            .ADDR_WIDTH  (AW),
            .NUM_WORDS   (NW),
            .READ_LATENCY(gi + 1),
            .INIT_FILE   ("")
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .a_address      (a_address),
            .a_byteenable   (a_byteenable),
            .a_chipselect   (a_chipselect),
            .a_read         (a_read),
            .a_write        (a_write),
            .a_writedata    (a_writedata),
            .a_clken        (a_clken),
            .a_waitrequest  (a_waitrequest[gi]),
            .a_readdata     (a_rdata[gi]),
            .a_readdatavalid(a_rvalid[gi]),
            .b_address      (b_address),
            .b_byteenable   (b_byteenable),
            .b_chipselect   (b_chipselect),
            .b_read         (b_read),
            .b_write        (b_write),
            .b_writedata    (b_writedata),
            .b_clken        (b_clken),
            .b_waitrequest  (b_waitrequest[gi]),
            .b_readdata     (b_rdata[gi]),
            .b_readdatavalid(b_rvalid[gi]),
            .collision_count(coll[gi])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ev_t e;
            if (a_rvalid[i]) begin
                e.cyc = 32'(cyc); e.port = 1'b0; e.inst = 1'(i); e.data = a_rdata[i];
                ev_q.push_back(e);
            end
            if (b_rvalid[i]) begin
                e.cyc = 32'(cyc); e.port = 1'b1; e.inst = 1'(i); e.data = b_rdata[i];
                ev_q.push_back(e);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    function automatic int n_ev(input int port, input int inst, input int min_cyc);
        int n = 0;
        foreach (ev_q[k]) begin
            if (ev_q[k].port == 1'(port) && ev_q[k].inst == 1'(inst) && int'(ev_q[k].cyc) >= min_cyc)
                n++;
        end
        return n;
    endfunction

    function automatic ev_t nth_ev(input int port, input int inst, input int idx);
        int n = 0;
        ev_t r = '0;
        foreach (ev_q[k]) begin
            if (ev_q[k].port == 1'(port) && ev_q[k].inst == 1'(inst)) begin
                if (n == idx) r = ev_q[k];
                n++;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_port(input int port);
        if (port == 0) begin
            a_chipselect = 1'b0; a_read = 1'b0; a_write = 1'b0;
        end else begin
            b_chipselect = 1'b0; b_read = 1'b0; b_write = 1'b0;
        end
    endtask

    task automatic idle();
        release_port(0);
        release_port(1);
        a_address = '0; a_byteenable = '0; a_writedata = '0; a_clken = 1'b1;
        b_address = '0; b_byteenable = '0; b_writedata = '0; b_clken = 1'b1;
    endtask

    task automatic drive(input int port, input logic rd, input logic wr,
                         input logic [AW-1:0] addr, input logic [3:0] be, input logic [DW-1:0] d);
        if (port == 0) begin
            a_chipselect = 1'b1; a_read = rd; a_write = wr;
            a_address = addr; a_byteenable = be; a_writedata = d;
        end else begin
            b_chipselect = 1'b1; b_read = rd; b_write = wr;
            b_address = addr; b_byteenable = be; b_writedata = d;
        end
    endtask

    task automatic wr_word(input int port, input logic [AW-1:0] addr,
                           input logic [3:0] be, input logic [DW-1:0] d);
        drive(port, 1'b0, 1'b1, addr, be, d);
        tick();
        release_port(port);
    endtask

    task automatic drain();
        repeat (5) tick();
    endtask

    // Clears the event log, issues one read and returns the cycle it was presented in.
    task automatic rd_capture(input int port, input logic [AW-1:0] addr, output int n);
        ev_q.delete();
        drive(port, 1'b1, 1'b0, addr, 4'hF, '0);
        n = cyc;
        tick();
        release_port(port);
        drain();
    endtask

    task automatic test_reset();
        int rst_cyc;
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (coll[i] !== 16'h0) $display("FAIL reset_count lat%0d: got %h expected 0000", i + 1, coll[i]);
            else passed++;
            total++;
            if (a_rdata[i] !== 32'h0 || b_rdata[i] !== 32'h0 || a_rvalid[i] !== 1'b0)
                $display("FAIL reset_outputs lat%0d: got a=%h b=%h v=%b expected 0 0 0",
                         i + 1, a_rdata[i], b_rdata[i], a_rvalid[i]);
            else passed++;
        end
        tick();
        // Leave state behind for the mid-burst reset to clear.
        wr_word(0, 8'd1, 4'hF, 32'h12345678);
        drive(0, 1'b0, 1'b1, 8'd2, 4'hF, 32'h1);
        drive(1, 1'b0, 1'b1, 8'd2, 4'hF, 32'h2);
        tick();
        release_port(0);
        release_port(1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (coll[i] !== 16'd1) $display("FAIL pre_reset_count lat%0d: got %h expected 0001", i + 1, coll[i]);
            else passed++;
        end
        tick();
        ev_q.delete();
        drive(0, 1'b1, 1'b0, 8'd1, 4'hF, '0);
        tick();
        tick();
        reset   = 1'b1;
        rst_cyc = cyc;
        tick();
        tick();
        reset = 1'b0;
        release_port(0);
        drain();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (n_ev(0, i, rst_cyc) !== 0)
                $display("FAIL reset_flush lat%0d: got %0d pulses expected 0", i + 1, n_ev(0, i, rst_cyc));
            else passed++;
            total++;
            if (a_rdata[i] !== 32'h0) $display("FAIL reset_readdata lat%0d: got %h expected 00000000", i + 1, a_rdata[i]);
            else passed++;
            total++;
            if (coll[i] !== 16'h0) $display("FAIL reset_count2 lat%0d: got %h expected 0000", i + 1, coll[i]);
            else passed++;
        end
        tick();
    endtask

    task automatic test_latency();
        int n;
        ev_t e;
        wr_word(0, 8'h10, 4'hF, 32'hDEADBEEF);
        rd_capture(0, 8'h10, n);
        for (int i = 0; i < 2; i++) begin
            e = nth_ev(0, i, 0);
            total++;
            if (n_ev(0, i, 0) !== 1) $display("FAIL latency_pulses lat%0d: got %0d expected 1", i + 1, n_ev(0, i, 0));
            else passed++;
            total++;
            if (e.cyc !== 32'(n + i + 1)) $display("FAIL latency_cycle lat%0d: got %0d expected %0d", i + 1, e.cyc, n + i + 1);
            else passed++;
            total++;
            if (e.data !== 32'hDEADBEEF) $display("FAIL latency_data lat%0d: got %h expected deadbeef", i + 1, e.data);
            else passed++;
        end
    endtask

    task automatic test_byte_lanes();
        int n;
        ev_t e;
        wr_word(0, 8'h20, 4'hF, 32'h11223344);
        wr_word(0, 8'h20, 4'b0101, 32'hAABBCCDD);
        rd_capture(1, 8'h20, n);
        for (int i = 0; i < 2; i++) begin
            e = nth_ev(1, i, 0);
            total++;
            if (n_ev(1, i, 0) !== 1 || e.data !== 32'h11BB33DD)
                $display("FAIL byte_lanes lat%0d: got %h (%0d pulses) expected 11bb33dd", i + 1, e.data, n_ev(1, i, 0));
            else passed++;
        end
    endtask

    task automatic test_collision();
        int n;
        ev_t e;
        drive(0, 1'b0, 1'b1, 8'h30, 4'b0011, 32'h000000AA);
        drive(1, 1'b0, 1'b1, 8'h30, 4'b1110, 32'hBBBBBB00);
        tick();
        release_port(0);
        release_port(1);
        rd_capture(0, 8'h30, n);
        for (int i = 0; i < 2; i++) begin
            e = nth_ev(0, i, 0);
            total++;
            if (e.data !== 32'hBBBB00AA) $display("FAIL collision_data lat%0d: got %h expected bbbb00aa", i + 1, e.data);
            else passed++;
            total++;
            if (coll[i] !== 16'd1) $display("FAIL collision_count lat%0d: got %h expected 0001", i + 1, coll[i]);
            else passed++;
        end
    endtask

    task automatic test_mixed_rdw();
        int n;
        ev_t e;
        wr_word(0, 8'd5, 4'hF, 32'd1);
        ev_q.delete();
        drive(0, 1'b0, 1'b1, 8'd5, 4'hF, 32'd2);
        drive(1, 1'b1, 1'b0, 8'd5, 4'hF, '0);
        n = cyc;
        tick();
        release_port(0);
        tick();
        release_port(1);
        drain();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (n_ev(1, i, 0) !== 2) $display("FAIL rdw_pulses lat%0d: got %0d expected 2", i + 1, n_ev(1, i, 0));
            else passed++;
            for (int k = 0; k < 2; k++) begin
                e = nth_ev(1, i, k);
                total++;
                if (e.data !== 32'(k + 1) || e.cyc !== 32'(n + k + i + 1))
                    $display("FAIL rdw_read%0d lat%0d: got %h @%0d expected %h @%0d",
                             k, i + 1, e.data, e.cyc, k + 1, n + k + i + 1);
                else passed++;
            end
        end
    endtask

    task automatic test_rw_same_port();
        int n;
        ev_t e;
        ev_q.delete();
        drive(0, 1'b1, 1'b1, 8'h50, 4'hF, 32'h5A5A0050);
        tick();
        release_port(0);
        drain();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (n_ev(0, i, 0) !== 0) $display("FAIL rw_no_valid lat%0d: got %0d pulses expected 0", i + 1, n_ev(0, i, 0));
            else passed++;
        end
        rd_capture(0, 8'h50, n);
        for (int i = 0; i < 2; i++) begin
            e = nth_ev(0, i, 0);
            total++;
            if (e.data !== 32'h5A5A0050) $display("FAIL rw_written lat%0d: got %h expected 5a5a0050", i + 1, e.data);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int n;
        ev_t e;
        logic [AW-1:0] addrs [5];
        logic [DW-1:0] exp_d [5];
        addrs = '{8'h44, 8'h40, 8'h41, 8'h42, 8'h43};
        exp_d = '{32'h44444444, 32'h40400000, 32'h40400001, 32'h40400002, 32'h40400003};
        for (int k = 0; k < 4; k++) begin
            drive(1, 1'b0, 1'b1, 8'(8'h40 + k), 4'hF, 32'h40400000 + 32'(k));
            tick();
        end
        release_port(1);
        ev_q.delete();
        // Read of 0x44 immediately follows its write on the same port.
        drive(0, 1'b0, 1'b1, 8'h44, 4'hF, 32'h44444444);
        tick();
        n = cyc;
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b1, 1'b0, addrs[k], 4'hF, '0);
            tick();
        end
        release_port(0);
        drain();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (n_ev(0, i, 0) !== 5) $display("FAIL b2b_pulses lat%0d: got %0d expected 5", i + 1, n_ev(0, i, 0));
            else passed++;
            for (int k = 0; k < 5; k++) begin
                e = nth_ev(0, i, k);
                total++;
                if (e.data !== exp_d[k] || e.cyc !== 32'(n + k + i + 1))
                    $display("FAIL b2b_read%0d lat%0d: got %h @%0d expected %h @%0d",
                             k, i + 1, e.data, e.cyc, exp_d[k], n + k + i + 1);
                else passed++;
            end
        end
    endtask

    task automatic test_stall();
        int n;
        ev_t e;
        int off [2][4];
        off = '{'{1, 5, 6, 7}, '{5, 6, 7, 8}};
        ev_q.delete();
        n = cyc;
        drive(1, 1'b1, 1'b0, 8'h40, 4'hF, '0);
        tick();
        drive(1, 1'b1, 1'b0, 8'h41, 4'hF, '0);
        tick();
        drive(1, 1'b1, 1'b0, 8'h42, 4'hF, '0);
        b_clken = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (b_waitrequest[i] !== 1'b1 || a_waitrequest[i] !== 1'b0)
                $display("FAIL stall_waitrequest lat%0d: got b=%b a=%b expected b=1 a=0",
                         i + 1, b_waitrequest[i], a_waitrequest[i]);
            else passed++;
        end
        tick();
        drive(0, 1'b1, 1'b0, 8'h44, 4'hF, '0);
        tick();
        release_port(0);
        tick();
        b_clken = 1'b1;
        tick();
        drive(1, 1'b1, 1'b0, 8'h43, 4'hF, '0);
        tick();
        release_port(1);
        drain();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (n_ev(1, i, 0) !== 4) $display("FAIL stall_pulses lat%0d: got %0d expected 4", i + 1, n_ev(1, i, 0));
            else passed++;
            for (int k = 0; k < 4; k++) begin
                e = nth_ev(1, i, k);
                total++;
                if (e.data !== 32'h40400000 + 32'(k) || e.cyc !== 32'(n + off[i][k]))
                    $display("FAIL stall_read%0d lat%0d: got %h @%0d expected %h @%0d",
                             k, i + 1, e.data, e.cyc, 32'h40400000 + 32'(k), n + off[i][k]);
                else passed++;
            end
            e = nth_ev(0, i, 0);
            total++;
            if (n_ev(0, i, 0) !== 1 || e.data !== 32'h44444444 || e.cyc !== 32'(n + 3 + i + 1))
                $display("FAIL stall_other_port lat%0d: got %h @%0d (%0d pulses) expected 44444444 @%0d",
                         i + 1, e.data, e.cyc, n_ev(0, i, 0), n + 3 + i + 1);
            else passed++;
        end
    endtask

    task automatic test_out_of_range();
        int n;
        ev_t e;
        wr_word(0, 8'd0, 4'hF, 32'h0000C0DE);
        wr_word(0, 8'(NW), 4'hF, 32'hBAD0BAD0);
        rd_capture(1, 8'(NW), n);
        for (int i = 0; i < 2; i++) begin
            e = nth_ev(1, i, 0);
            total++;
            if (n_ev(1, i, 0) !== 1 || e.data !== 32'h0 || e.cyc !== 32'(n + i + 1))
                $display("FAIL oor_read lat%0d: got %h @%0d (%0d pulses) expected 00000000 @%0d",
                         i + 1, e.data, e.cyc, n_ev(1, i, 0), n + i + 1);
            else passed++;
        end
        rd_capture(0, 8'd0, n);
        for (int i = 0; i < 2; i++) begin
            e = nth_ev(0, i, 0);
            total++;
            if (e.data !== 32'h0000C0DE) $display("FAIL oor_write_dropped lat%0d: got %h expected 0000c0de", i + 1, e.data);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        drive(0, 1'b0, 1'b1, 8'h60, 4'hF, 32'h1);
        drive(1, 1'b0, 1'b1, 8'h60, 4'hF, 32'h2);
        repeat (10) tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (coll[i] !== 16'd11) $display("FAIL count_increment lat%0d: got %h expected 000b", i + 1, coll[i]);
            else passed++;
        end
        repeat (65530) tick();
        release_port(0);
        release_port(1);
        tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (coll[i] !== 16'hFFFF) $display("FAIL count_saturate lat%0d: got %h expected ffff", i + 1, coll[i]);
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_latency();
        test_byte_lanes();
        test_collision();
        test_mixed_rdw();
        test_rw_same_port();
        test_back_to_back();
        test_stall();
        test_out_of_range();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
